// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two CPU ports, the arbiter and the memory controller.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_bus_arbiter_if;
    logic        m0_req_in,     m1_req_in;
    logic [31:0] m0_addr_in,    m1_addr_in;
    logic [31:0] m0_wr_data_in, m1_wr_data_in;
    logic        m0_we_in,      m1_we_in;
    logic        m0_lock_in,    m1_lock_in;
    logic        m0_gnt_out,    m1_gnt_out;
    logic [31:0] m0_rd_data_out, m1_rd_data_out;
    logic        m0_rvalid_out, m1_rvalid_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_wr_data_out;
    logic        mem_we_out;
    logic [31:0] mem_rd_data_in;

    modport slave (
        input  m0_req_in, m1_req_in, m0_addr_in, m1_addr_in,
        input  m0_wr_data_in, m1_wr_data_in, m0_we_in, m1_we_in,
        input  m0_lock_in, m1_lock_in, mem_rd_data_in,
        output m0_gnt_out, m1_gnt_out, m0_rd_data_out, m1_rd_data_out,
        output m0_rvalid_out, m1_rvalid_out,
        output mem_addr_out, mem_wr_data_out, mem_we_out
    );

    modport master (
        output m0_req_in, m1_req_in, m0_addr_in, m1_addr_in,
        output m0_wr_data_in, m1_wr_data_in, m0_we_in, m1_we_in,
        output m0_lock_in, m1_lock_in, mem_rd_data_in,
        input  m0_gnt_out, m1_gnt_out, m0_rd_data_out, m1_rd_data_out,
        input  m0_rvalid_out, m1_rvalid_out,
        input  mem_addr_out, mem_wr_data_out, mem_we_out
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for two CPU ports onto one memory bus, with bounded
// bus lock and a fixed-latency read tag pipeline routing rd_data back.
//
// lock state | meaning
// LK_NONE    | no port holds the bus; ties resolved round-robin
// LK_M0      | m0 holds the lock; wins ties while r_lock_cnt < MAX_LOCK
// LK_M1      | m1 holds the lock; wins ties while r_lock_cnt < MAX_LOCK
module mem_bus_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_LOCK   = 8
) (
    input logic              clk_in,
    input logic              rst_in,
    mem_bus_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_CAP = CW'(MAX_LOCK);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_M0   = 2'd1,
        LK_M1   = 2'd2
    } lock_e;

    lock_e                 r_lock, w_lock_nxt, w_gnt_owner;
    logic [CW-1:0]         r_lock_cnt, w_lock_cnt_nxt;
    logic                  r_last_gnt;
    logic [RD_LATENCY-1:0] r_tag_v, r_tag_id;
    logic                  w_gnt0, w_gnt1, w_gnt_any, w_gnt_id;
    logic                  w_gnt_lock, w_gnt_we, w_lock_hold, w_tag_new;

    assign w_lock_hold = (r_lock != LK_NONE) && (r_lock_cnt < LOCK_CAP);

    // Grants are gated by reset directly so they drop asynchronously.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_in) begin
            if (bus.m0_req_in && bus.m1_req_in) begin
                if (w_lock_hold) begin
                    w_gnt0 = (r_lock == LK_M0);
                    w_gnt1 = (r_lock == LK_M1);
                end else begin
                    w_gnt0 = r_last_gnt;
                    w_gnt1 = ~r_last_gnt;
                end
            end else begin
                w_gnt0 = bus.m0_req_in;
                w_gnt1 = bus.m1_req_in;
            end
        end
    end

    assign w_gnt_any  = w_gnt0 | w_gnt1;
    assign w_gnt_id   = w_gnt1;
    assign w_gnt_lock = w_gnt1 ? bus.m1_lock_in : bus.m0_lock_in;
    assign w_gnt_we   = w_gnt1 ? bus.m1_we_in : bus.m0_we_in;
    assign w_tag_new  = w_gnt_any & ~w_gnt_we;

    always_comb begin
        w_gnt_owner    = w_gnt_id ? LK_M1 : LK_M0;
        w_lock_nxt     = r_lock;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_gnt_any) begin
            if (!w_gnt_lock) begin
                w_lock_nxt     = LK_NONE;
                w_lock_cnt_nxt = '0;
            end else if (r_lock == w_gnt_owner) begin
                if (r_lock_cnt < LOCK_CAP) begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
                end
            end else begin
                w_lock_nxt     = w_gnt_owner;
                w_lock_cnt_nxt = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_lock     <= LK_NONE;
            r_lock_cnt <= '0;
            r_last_gnt <= 1'b1;
        end else begin
            r_lock     <= w_lock_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt_any) begin
                r_last_gnt <= w_gnt_id;
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_tag_one
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= w_tag_new;
                    r_tag_id <= w_gnt_id;
                end
            end
        end else begin : g_tag_many
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_tag_v  <= '0;
                    r_tag_id <= '0;
                end else begin
                    r_tag_v  <= {r_tag_v[RD_LATENCY-2:0], w_tag_new};
                    r_tag_id <= {r_tag_id[RD_LATENCY-2:0], w_gnt_id};
                end
            end
        end
    endgenerate

    assign bus.m0_gnt_out      = w_gnt0;
    assign bus.m1_gnt_out      = w_gnt1;
    assign bus.mem_addr_out    = w_gnt0 ? bus.m0_addr_in :
                                 (w_gnt1 ? bus.m1_addr_in : 32'd0);
    assign bus.mem_wr_data_out = w_gnt0 ? bus.m0_wr_data_in :
                                 (w_gnt1 ? bus.m1_wr_data_in : 32'd0);
    assign bus.mem_we_out      = (w_gnt0 & bus.m0_we_in) | (w_gnt1 & bus.m1_we_in);
    assign bus.m0_rd_data_out  = bus.mem_rd_data_in;
    assign bus.m1_rd_data_out  = bus.mem_rd_data_in;
    assign bus.m0_rvalid_out   = r_tag_v[RD_LATENCY-1] & ~r_tag_id[RD_LATENCY-1];
    assign bus.m1_rvalid_out   = r_tag_v[RD_LATENCY-1] & r_tag_id[RD_LATENCY-1];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (read latency 1 and 3) driven in
// lockstep and compared each cycle against a rule-level arbitration model.
module tb_mem_bus_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MAXL  = 4;

    typedef struct {
        int due;
        int id;
    } tag_t;

    typedef struct {
        bit r0, r1, w0, w1, l0, l1;
        int exp_g;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    mem_bus_arbiter_if bus_a ();
    mem_bus_arbiter_if bus_b ();

    mem_bus_arbiter #(.RD_LATENCY(LAT_A), .MAX_LOCK(MAXL)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a));
    mem_bus_arbiter #(.RD_LATENCY(LAT_B), .MAX_LOCK(MAXL)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b));

    logic        s_g0[2], s_g1[2], s_we[2], s_rv0[2], s_rv1[2];
    logic [31:0] s_addr[2], s_wd[2], s_rd0[2], s_rd1[2];
    assign s_g0[0] = bus_a.m0_gnt_out;        assign s_g0[1] = bus_b.m0_gnt_out;
    assign s_g1[0] = bus_a.m1_gnt_out;        assign s_g1[1] = bus_b.m1_gnt_out;
    assign s_we[0] = bus_a.mem_we_out;        assign s_we[1] = bus_b.mem_we_out;
    assign s_rv0[0] = bus_a.m0_rvalid_out;    assign s_rv0[1] = bus_b.m0_rvalid_out;
    assign s_rv1[0] = bus_a.m1_rvalid_out;    assign s_rv1[1] = bus_b.m1_rvalid_out;
    assign s_addr[0] = bus_a.mem_addr_out;    assign s_addr[1] = bus_b.mem_addr_out;
    assign s_wd[0] = bus_a.mem_wr_data_out;   assign s_wd[1] = bus_b.mem_wr_data_out;
    assign s_rd0[0] = bus_a.m0_rd_data_out;   assign s_rd0[1] = bus_b.m0_rd_data_out;
    assign s_rd1[0] = bus_a.m1_rd_data_out;   assign s_rd1[1] = bus_b.m1_rd_data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state: last granted port, lock owner (-1 none), lock run length
    int   m_last, m_owner, m_run;
    tag_t q_a[$], q_b[$];

    int          cnt_rv0[2], cnt_rv1[2], cnt_we[2], rv_cyc[2];
    logic [31:0] last_rd0[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (!r0 && !r1) return -1;
        if (r0 != r1) return r1 ? 1 : 0;
        if (m_owner >= 0 && m_run < MAXL) return m_owner;
        return 1 - m_last;
    endfunction

    function automatic void model_reset();
        m_last  = 1;
        m_owner = -1;
        m_run   = 0;
        q_a.delete();
        q_b.delete();
    endfunction

    function automatic void zero_counts();
        for (int k = 0; k < 2; k++) begin
            cnt_rv0[k] = 0; cnt_rv1[k] = 0; cnt_we[k] = 0; rv_cyc[k] = -1;
            last_rd0[k] = '0;
        end
    endfunction

    task automatic head(input int k, output bit v, output int id);
        v = 1'b0;
        id = 0;
        if (k == 0) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin
                v = 1'b1; id = q_a[0].id; void'(q_a.pop_front());
            end
        end else begin
            if (q_b.size() > 0 && q_b[0].due == cyc) begin
                v = 1'b1; id = q_b[0].id; void'(q_b.pop_front());
            end
        end
    endtask

    task automatic drive(input bit r0, r1, w0, w1, l0, l1,
                         input logic [31:0] a0, a1, d0, d1, rd);
        bus_a.m0_req_in = r0;     bus_b.m0_req_in = r0;
        bus_a.m1_req_in = r1;     bus_b.m1_req_in = r1;
        bus_a.m0_we_in = w0;      bus_b.m0_we_in = w0;
        bus_a.m1_we_in = w1;      bus_b.m1_we_in = w1;
        bus_a.m0_lock_in = l0;    bus_b.m0_lock_in = l0;
        bus_a.m1_lock_in = l1;    bus_b.m1_lock_in = l1;
        bus_a.m0_addr_in = a0;    bus_b.m0_addr_in = a0;
        bus_a.m1_addr_in = a1;    bus_b.m1_addr_in = a1;
        bus_a.m0_wr_data_in = d0; bus_b.m0_wr_data_in = d0;
        bus_a.m1_wr_data_in = d1; bus_b.m1_wr_data_in = d1;
        bus_a.mem_rd_data_in = rd; bus_b.mem_rd_data_in = rd;
    endtask

    // One bus cycle: apply inputs, compare mid-cycle, advance model at the edge.
    task automatic step(input bit r0, r1, w0, w1, l0, l1,
                        input logic [31:0] a0, a1, d0, d1, rd,
                        output int g, output int ga, output int gb);
        bit          ev;
        int          eid;
        bit          ewe, lk;
        logic [31:0] ea, ewd;
        string       p;
        int          obs[2];
        drive(r0, r1, w0, w1, l0, l1, a0, a1, d0, d1, rd);
        g   = pick(r0, r1);
        ea  = (g == 0) ? a0 : (g == 1) ? a1 : 32'd0;
        ewd = (g == 0) ? d0 : (g == 1) ? d1 : 32'd0;
        ewe = (g == 0) ? w0 : (g == 1) ? w1 : 1'b0;
        #4;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "a" : "b";
            head(k, ev, eid);
            chk({p, ".gnt0"}, 32'(s_g0[k]), 32'(g == 0));
            chk({p, ".gnt1"}, 32'(s_g1[k]), 32'(g == 1));
            chk({p, ".mem_we"}, 32'(s_we[k]), 32'(ewe));
            chk({p, ".mem_addr"}, s_addr[k], ea);
            chk({p, ".mem_wdata"}, s_wd[k], ewd);
            chk({p, ".rvalid0"}, 32'(s_rv0[k]), 32'(ev && eid == 0));
            chk({p, ".rvalid1"}, 32'(s_rv1[k]), 32'(ev && eid == 1));
            if (ev) chk({p, ".rd_data"}, (eid == 1) ? s_rd1[k] : s_rd0[k], rd);
            if (s_rv0[k] === 1'b1) begin
                cnt_rv0[k]++; last_rd0[k] = s_rd0[k]; rv_cyc[k] = cyc;
            end
            if (s_rv1[k] === 1'b1) begin
                cnt_rv1[k]++; rv_cyc[k] = cyc;
            end
            if (s_we[k] === 1'b1) cnt_we[k]++;
            obs[k] = (s_g0[k] === 1'b1 && s_g1[k] === 1'b1) ? 2 :
                     (s_g0[k] === 1'b1) ? 0 : (s_g1[k] === 1'b1) ? 1 : -1;
        end
        ga = obs[0];
        gb = obs[1];
        @(posedge clk_in);
        #1;
        if (g >= 0) begin
            lk = (g == 1) ? l1 : l0;
            m_last = g;
            if (!lk) begin
                m_owner = -1; m_run = 0;
            end else if (m_owner == g) begin
                if (m_run < MAXL) m_run++;
            end else begin
                m_owner = g; m_run = 1;
            end
            if (!ewe) begin
                q_a.push_back('{due: cyc + LAT_A, id: g});
                q_b.push_back('{due: cyc + LAT_B, id: g});
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        int g, ga, gb;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, $urandom, g, ga, gb);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, ".gnt0"}, 32'(s_g0[k]), 0);
            chk({nm, ".gnt1"}, 32'(s_g1[k]), 0);
            chk({nm, ".rvalid0"}, 32'(s_rv0[k]), 0);
            chk({nm, ".rvalid1"}, 32'(s_rv1[k]), 0);
            chk({nm, ".mem_we"}, 32'(s_we[k]), 0);
            chk({nm, ".mem_addr"}, s_addr[k], 0);
            chk({nm, ".mem_wdata"}, s_wd[k], 0);
        end
    endtask

    vec_t        tbl[19];
    bit          p_req[2], p_we[2], p_lock[2];
    logic [31:0] p_addr[2], p_wd[2];

    initial begin
        int g, ga, gb, acc;
        // contention, lock cap (m1 x4 then m0), single-requester and lock release rows
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        rst_in = 1'b1;
        drive(1, 1, 1, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0);
        model_reset();
        zero_counts();
        #2;
        chk_all_zero("reset");
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].l0, tbl[i].l1,
                 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'hA000 + 32'(i),
                 32'hB000 + 32'(i), $urandom, g, ga, gb);
            chk($sformatf("vec%0d.gnt_a", i), 32'(ga), 32'(tbl[i].exp_g));
            chk($sformatf("vec%0d.gnt_b", i), 32'(gb), 32'(tbl[i].exp_g));
        end
        idle(4);

        // single read: data returned on the next cycle for latency 1
        zero_counts();
        step(1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0, g, ga, gb);
        chk("single.gnt", 32'(ga), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, g, ga, gb);
        chk("single.rvalid_cnt", 32'(cnt_rv0[0]), 1);
        chk("single.rd_data", last_rd0[0], 32'hDEADBEEF);
        idle(3);
        chk("single.m1_rvalid_cnt", 32'(cnt_rv1[0] + cnt_rv1[1]), 0);

        // write then read: one mem_we pulse, one m0 response at acceptance+latency
        zero_counts();
        step(0, 1, 0, 1, 0, 0, 0, 32'h200, 0, 32'h55, 0, g, ga, gb);
        acc = cyc;
        step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, g, ga, gb);
        idle(5);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr_rd.we_cnt%0d", k), 32'(cnt_we[k]), 1);
            chk($sformatf("wr_rd.rv0_cnt%0d", k), 32'(cnt_rv0[k]), 1);
            chk($sformatf("wr_rd.rv1_cnt%0d", k), 32'(cnt_rv1[k]), 0);
        end
        chk("wr_rd.lat_a", 32'(rv_cyc[0]), 32'(acc + LAT_A));
        chk("wr_rd.lat_b", 32'(rv_cyc[1]), 32'(acc + LAT_B));

        // reset while two reads are in flight, leaving last grant on m0
        step(0, 1, 0, 0, 0, 1, 0, 32'h300, 0, 0, 0, g, ga, gb);
        step(1, 0, 0, 0, 1, 0, 32'h304, 0, 0, 0, 0, g, ga, gb);
        drive(1, 1, 1, 1, 0, 0, 32'h400, 32'h404, 32'h1, 32'h2, 0);
        #1;
        rst_in = 1'b1;
        model_reset();
        #2;
        chk_all_zero("midreset");
        @(posedge clk_in);
        #1;
        chk_all_zero("midreset_edge");
        rst_in = 1'b0;
        cyc++;
        zero_counts();
        step(1, 1, 1, 1, 0, 0, 32'h400, 32'h404, 32'h1, 32'h2, 0, g, ga, gb);
        chk("post_reset.tie_a", 32'(ga), 0);
        chk("post_reset.tie_b", 32'(gb), 0);
        step(0, 1, 0, 1, 0, 0, 0, 32'h404, 0, 32'h2, 0, g, ga, gb);
        idle(5);
        chk("post_reset.no_rvalid", 32'(cnt_rv0[0] + cnt_rv1[0] + cnt_rv0[1] + cnt_rv1[1]), 0);

        // random traffic with requests held until granted
        for (int j = 0; j < 2; j++) p_req[j] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!p_req[j] && $urandom_range(1, 0) == 1) begin
                    p_req[j]  = 1'b1;
                    p_we[j]   = ($urandom_range(3, 0) == 0);
                    p_lock[j] = ($urandom_range(3, 0) != 0);
                    p_addr[j] = $urandom;
                    p_wd[j]   = $urandom;
                end
            end
            step(p_req[0], p_req[1], p_we[0], p_we[1], p_lock[0], p_lock[1],
                 p_addr[0], p_addr[1], p_wd[0], p_wd[1], $urandom, g, ga, gb);
            if (g >= 0) p_req[g] = 1'b0;
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
